// File: rtl/lives_if.sv
// Bundle of per-frame events, pixel coordinates and life/icon status
// exchanged between the game pipeline (master) and lives_manager (slave).
interface lives_if;
    logic        startOfFrame;
    logic        playGame;
    logic        playerHit;
    logic        extraLife;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [2:0]  lives;
    logic        invincible;
    logic        gameOver;
    logic        iconInside;
    logic [10:0] iconOffsetX;
    logic [10:0] iconOffsetY;

    modport master (
        output startOfFrame, playGame, playerHit, extraLife,
        output pixelX, pixelY,
        input  lives, invincible, gameOver,
        input  iconInside, iconOffsetX, iconOffsetY
    );

    modport slave (
        input  startOfFrame, playGame, playerHit, extraLife,
        input  pixelX, pixelY,
        output lives, invincible, gameOver,
        output iconInside, iconOffsetX, iconOffsetY
    );
endinterface

// File: rtl/lives_manager.sv
// Player lives controller: lives count, hit/bonus handling, post-hit
// blink window, game-over, and registered life-icon window generation.
// Ports: clk, resetN (sync active-high), bus (lives_if.slave).
module lives_manager #(
    parameter int START_LIVES  = 3,
    parameter int MAX_LIVES    = 5,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_PERIOD = 8,
    parameter int ICON_W       = 16,
    parameter int ICON_H       = 16,
    parameter int ICON_GAP     = 4,
    parameter int ICONS_X      = 80,
    parameter int ICONS_Y      = 8
) (
    input  logic   clk,
    input  logic   resetN,
    lives_if.slave bus
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ALIVE     = 2'd1;
    localparam logic [1:0] S_HIT_BLINK = 2'd2;
    localparam logic [1:0] S_GAME_OVER = 2'd3;

    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int PW = $clog2(BLINK_PERIOD + 1);

    localparam logic [2:0]    START_L = 3'(START_LIVES);
    localparam logic [2:0]    MAX_L   = 3'(MAX_LIVES);
    localparam logic [FW-1:0] FRAMES  = FW'(BLINK_FRAMES);
    localparam logic [PW-1:0] PH_LAST = PW'(BLINK_PERIOD - 1);
    localparam logic [10:0]   TOP     = 11'(ICONS_Y);
    localparam logic [10:0]   BOT     = 11'(ICONS_Y + ICON_H);

    logic [1:0]    state_q, state_d;
    logic [2:0]    lives_q, lives_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          blink_q, blink_d;

    logic          icon_in_q, icon_in_d;
    logic [10:0]   offx_q, offx_d;
    logic [10:0]   offy_q, offy_d;

    logic [2:0]    lives_inc;

    assign lives_inc = (lives_q >= MAX_L) ? lives_q : lives_q + 3'd1;

    // ---------------- lives / blink FSM ----------------
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        frame_d = frame_q;
        phase_d = phase_q;
        blink_d = blink_q;

        // Dropping playGame aborts the game and beats every other event.
        if (state_q != S_IDLE && !bus.playGame) begin
            state_d = S_IDLE;
            lives_d = START_L;
            frame_d = '0;
            phase_d = '0;
            blink_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    lives_d = START_L;
                    if (bus.playGame) begin
                        state_d = S_ALIVE;
                    end
                end
                S_ALIVE: begin
                    if (bus.playerHit) begin
                        // A bonus in the same cycle cancels the loss, so
                        // this path can never end the game.
                        if (bus.extraLife || lives_q > 3'd1) begin
                            if (!bus.extraLife) begin
                                lives_d = lives_q - 3'd1;
                            end
                            state_d = S_HIT_BLINK;
                            frame_d = FRAMES;
                            phase_d = '0;
                            blink_d = 1'b0;
                        end else begin
                            lives_d = 3'd0;
                            state_d = S_GAME_OVER;
                        end
                    end else if (bus.extraLife) begin
                        lives_d = lives_inc;
                    end
                end
                S_HIT_BLINK: begin
                    if (bus.extraLife) begin
                        lives_d = lives_inc;
                    end
                    if (bus.startOfFrame) begin
                        if (frame_q == FW'(1)) begin
                            state_d = S_ALIVE;
                            frame_d = '0;
                            phase_d = '0;
                            blink_d = 1'b0;
                        end else begin
                            frame_d = frame_q - FW'(1);
                            if (phase_q == PH_LAST) begin
                                phase_d = '0;
                                blink_d = ~blink_q;
                            end else begin
                                phase_d = phase_q + PW'(1);
                            end
                        end
                    end
                end
                S_GAME_OVER: begin
                    state_d = S_GAME_OVER;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ---------------- icon slot decode ----------------
    logic [MAX_LIVES-1:0] slot_in;
    logic [10:0]          slot_offx [MAX_LIVES];
    logic                 y_in;
    logic                 blinking;

    assign y_in     = (bus.pixelY >= TOP) && (bus.pixelY < BOT);
    assign blinking = (state_q == S_HIT_BLINK) && blink_q;

    for (genvar g = 0; g < MAX_LIVES; g++) begin : g_slot
        localparam logic [10:0] LEFT =
            11'(ICONS_X + g * (ICON_W + ICON_GAP));
        localparam logic [10:0] RIGHT =
            11'(ICONS_X + g * (ICON_W + ICON_GAP) + ICON_W);
        localparam logic [2:0] IDX = 3'(g);

        logic x_in;
        logic vis;

        assign x_in = (bus.pixelX >= LEFT) && (bus.pixelX < RIGHT);
        // The icon just lost (index == lives) blinks during invincibility.
        assign vis  = (IDX < lives_q) || (blinking && IDX == lives_q);
        assign slot_in[g]   = x_in && y_in && vis;
        assign slot_offx[g] = slot_in[g] ? (bus.pixelX - LEFT) : 11'd0;
    end

    // Slots never overlap, so OR-combining the masked offsets is exact.
    always_comb begin
        icon_in_d = 1'b0;
        offx_d    = '0;
        for (int k = 0; k < MAX_LIVES; k++) begin
            icon_in_d = icon_in_d | slot_in[k];
            offx_d    = offx_d | slot_offx[k];
        end
        offy_d = icon_in_d ? (bus.pixelY - TOP) : 11'd0;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q   <= S_IDLE;
            lives_q   <= START_L;
            frame_q   <= '0;
            phase_q   <= '0;
            blink_q   <= 1'b0;
            icon_in_q <= 1'b0;
            offx_q    <= '0;
            offy_q    <= '0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            blink_q   <= blink_d;
            icon_in_q <= icon_in_d;
            offx_q    <= offx_d;
            offy_q    <= offy_d;
        end
    end

    assign bus.lives       = lives_q;
    assign bus.invincible  = (state_q == S_HIT_BLINK);
    assign bus.gameOver    = (state_q == S_GAME_OVER);
    assign bus.iconInside  = icon_in_q;
    assign bus.iconOffsetX = offx_q;
    assign bus.iconOffsetY = offy_q;

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager: vector table for start/icons/bonus,
// hand sequences for blink window, game over, simultaneous events, aborts.
module tb_lives_manager;

    logic clk = 1'b0;
    logic resetN;

    lives_if bus();

    lives_manager dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        bit pg, hit, ext, sof;
        int x, y;
        int lv, inv, go, in_, ox, oy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit pg, bit hit, bit ext, bit sof,
                                int x, int y, int lv, int inv, int go,
                                int in_, int ox, int oy);
        vec_t v;
        v.pg = pg; v.hit = hit; v.ext = ext; v.sof = sof;
        v.x = x; v.y = y;
        v.lv = lv; v.inv = inv; v.go = go;
        v.in_ = in_; v.ox = ox; v.oy = oy;
        return v;
    endfunction

    task automatic chk(string nm, int got, int exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.playerHit    = 1'b0;
        bus.extraLife    = 1'b0;
        bus.startOfFrame = 1'b0;
    endtask

    task automatic frames(int n);
        for (int i = 0; i < n; i++) begin
            bus.startOfFrame = 1'b1;
            cyc();
        end
    endtask

    task automatic chk_status(string nm, int lv, int inv, int go);
        chk({nm, " lives"}, int'(bus.lives), lv);
        chk({nm, " invincible"}, int'(bus.invincible), inv);
        chk({nm, " gameOver"}, int'(bus.gameOver), go);
    endtask

    task automatic chk_icon(string nm, int in_, int ox, int oy);
        chk({nm, " iconInside"}, int'(bus.iconInside), in_);
        chk({nm, " offX"}, int'(bus.iconOffsetX), ox);
        chk({nm, " offY"}, int'(bus.iconOffsetY), oy);
    endtask

    initial begin
        //           pg h e s   x    y  lv i g in ox oy
        tbl.push_back(mk(1,0,0,0,  80,  8, 3,0,0,1, 0, 0));
        tbl.push_back(mk(1,0,0,0,  95, 23, 3,0,0,1,15,15));
        tbl.push_back(mk(1,0,0,0,  96,  8, 3,0,0,0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 100,  8, 3,0,0,1, 0, 0));
        tbl.push_back(mk(1,0,0,0, 115, 10, 3,0,0,1,15, 2));
        tbl.push_back(mk(1,0,0,0, 120, 23, 3,0,0,1, 0,15));
        tbl.push_back(mk(1,0,0,0, 135,  8, 3,0,0,1,15, 0));
        tbl.push_back(mk(1,0,0,0, 140,  8, 3,0,0,0, 0, 0));
        tbl.push_back(mk(1,0,0,0,  90, 24, 3,0,0,0, 0, 0));
        tbl.push_back(mk(1,0,0,0,  90,  7, 3,0,0,0, 0, 0));
        tbl.push_back(mk(1,0,0,0,  79,  8, 3,0,0,0, 0, 0));
        tbl.push_back(mk(1,0,1,0, 140,  8, 4,0,0,0, 0, 0));
        tbl.push_back(mk(1,0,1,0, 140,  8, 5,0,0,1, 0, 0));
        tbl.push_back(mk(1,0,1,0, 160,  8, 5,0,0,1, 0, 0));
        tbl.push_back(mk(1,0,1,0, 175, 23, 5,0,0,1,15,15));
        tbl.push_back(mk(1,0,1,0, 176,  8, 5,0,0,0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 180,  8, 5,0,0,0, 0, 0));
        tbl.push_back(mk(1,0,0,1,   0,  0, 5,0,0,0, 0, 0));
        tbl.push_back(mk(1,1,0,0,   0,  0, 4,1,0,0, 0, 0));
        tbl.push_back(mk(1,1,0,0,   0,  0, 4,1,0,0, 0, 0));
        tbl.push_back(mk(1,0,1,0,   0,  0, 5,1,0,0, 0, 0));
        tbl.push_back(mk(0,0,0,0,   0,  0, 3,0,0,0, 0, 0));
        tbl.push_back(mk(0,1,1,0,   0,  0, 3,0,0,0, 0, 0));

        resetN           = 1'b1;
        bus.playGame     = 1'b0;
        bus.playerHit    = 1'b0;
        bus.extraLife    = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.pixelX       = 11'd80;
        bus.pixelY       = 11'd8;
        repeat (3) cyc();
        chk_status("reset", 3, 0, 0);
        chk_icon("reset", 0, 0, 0);
        resetN = 1'b0;
        bus.pixelX = 11'd0;
        bus.pixelY = 11'd0;
        cyc();

        // Table: start, icon sweep, bonus saturation, hit, abort.
        for (int i = 0; i < tbl.size(); i++) begin
            bus.playGame     = tbl[i].pg;
            bus.playerHit    = tbl[i].hit;
            bus.extraLife    = tbl[i].ext;
            bus.startOfFrame = tbl[i].sof;
            bus.pixelX       = 11'(tbl[i].x);
            bus.pixelY       = 11'(tbl[i].y);
            cyc();
            chk_status($sformatf("v%0d", i),
                       tbl[i].lv, tbl[i].inv, tbl[i].go);
            chk_icon($sformatf("v%0d", i),
                     tbl[i].in_, tbl[i].ox, tbl[i].oy);
        end

        // Hit and blink window on slot 2.
        bus.playGame = 1'b1;
        cyc();
        chk_status("start2", 3, 0, 0);
        bus.playerHit = 1'b1;
        cyc();
        chk_status("hit1", 2, 1, 0);
        bus.pixelX = 11'd120;
        bus.pixelY = 11'd8;
        for (int i = 1; i <= 60; i++) begin
            bus.startOfFrame = 1'b1;
            cyc();
            chk($sformatf("blink f%0d invincible", i),
                int'(bus.invincible), (i < 60) ? 1 : 0);
            if (i == 30) bus.playerHit = 1'b1;
            cyc();
            chk($sformatf("blink f%0d slot2", i), int'(bus.iconInside),
                (i < 60 && ((i / 8) % 2) == 1) ? 1 : 0);
            if (i == 30) chk("hit in window lives", int'(bus.lives), 2);
        end
        chk_status("blink end", 2, 0, 0);

        // Run down to game over.
        bus.playerHit = 1'b1;
        cyc();
        chk_status("hit2", 1, 1, 0);
        frames(60);
        chk_status("hit2 end", 1, 0, 0);
        bus.playerHit = 1'b1;
        cyc();
        chk_status("hit3", 0, 0, 1);
        bus.pixelX = 11'd80;
        for (int i = 0; i < 4; i++) begin
            bus.playerHit    = 1'b1;
            bus.extraLife    = 1'b1;
            bus.startOfFrame = 1'b1;
            cyc();
            chk_status($sformatf("over hold%0d", i), 0, 0, 1);
            chk($sformatf("over hold%0d icon", i), int'(bus.iconInside), 0);
        end
        bus.playGame = 1'b0;
        cyc();
        chk_status("over exit", 3, 0, 0);

        // Simultaneous hit and bonus at one life.
        bus.playGame = 1'b1;
        cyc();
        bus.playerHit = 1'b1;
        cyc();
        frames(60);
        bus.playerHit = 1'b1;
        cyc();
        frames(60);
        chk_status("one life", 1, 0, 0);
        bus.playerHit = 1'b1;
        bus.extraLife = 1'b1;
        cyc();
        chk_status("hit+bonus", 1, 1, 0);
        bus.pixelX = 11'd100;
        frames(8);
        cyc();
        chk_icon("slot1 blink", 1, 0, 0);
        bus.pixelX = 11'd80;
        cyc();
        chk_icon("slot0 at one", 1, 0, 0);

        // Reset mid-blink.
        resetN = 1'b1;
        cyc();
        chk_status("reset blink", 3, 0, 0);
        chk_icon("reset blink", 0, 0, 0);
        resetN = 1'b0;
        cyc();
        chk_status("restart", 3, 0, 0);
        chk_icon("restart", 1, 0, 0);

        // playGame drop mid-blink.
        bus.playerHit = 1'b1;
        cyc();
        chk_status("hit4", 2, 1, 0);
        frames(10);
        bus.pixelX = 11'd0;
        bus.playGame = 1'b0;
        cyc();
        chk_status("abort", 3, 0, 0);
        chk_icon("abort", 0, 0, 0);

        // Window reloads in full after an abort.
        bus.playGame = 1'b1;
        cyc();
        bus.playerHit = 1'b1;
        cyc();
        frames(59);
        chk("reload f59 invincible", int'(bus.invincible), 1);
        frames(1);
        chk("reload f60 invincible", int'(bus.invincible), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
